// File: rtl/victim_wb_ctrl.sv
// Write-back drain controller: streams the victim FIFO head line to memory as an
// incrementing burst and pops the entry only after the write response returns.
package victim_wb_pkg;
  typedef logic [31:0] phys_t;
endpackage

module victim_wb_ctrl
  import victim_wb_pkg::*;
#(
  parameter int  LINE_WIDTH       = 256,
  parameter int  BUS_WIDTH        = 32,
  localparam int BEATS            = LINE_WIDTH / BUS_WIDTH,
  localparam int LINE_BYTE_OFFSET = $clog2(LINE_WIDTH / 8),
  localparam int PHYS_WIDTH       = $bits(phys_t),
  localparam int LABEL_WIDTH      = PHYS_WIDTH - LINE_BYTE_OFFSET,
  localparam int BEAT_W           = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LABEL_WIDTH+LINE_WIDTH-1:0] vc_rline,
  input  logic                              vc_empty,
  output logic                              vc_pop,
  input  logic [LABEL_WIDTH-1:0]            query_label,
  output logic                              lock_hit,
  input  logic                              flush_req,
  output logic                              flush_done,
  output logic [PHYS_WIDTH-1:0]             awaddr,
  output logic [7:0]                        awlen,
  output logic                              awvalid,
  input  logic                              awready,
  output logic [BUS_WIDTH-1:0]              wdata,
  output logic [BUS_WIDTH/8-1:0]            wstrb,
  output logic                              wlast,
  output logic                              wvalid,
  input  logic                              wready,
  input  logic                              bvalid,
  output logic                              bready,
  input  logic [1:0]                        bresp,
  output logic                              bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [LABEL_WIDTH-1:0]  label_q, label_d;
  logic [LINE_WIDTH-1:0]   data_q,  data_d;
  logic [BEAT_W-1:0]       beat_q,  beat_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      label_q <= '0;
      data_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      label_q <= label_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    label_d = label_q;
    data_d  = data_q;
    beat_d  = beat_q;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b0;
    vc_pop  = 1'b0;
    bus_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!vc_empty) begin
          {label_d, data_d} = vc_rline;
          state_d           = S_ADDR;
        end
      end
      S_ADDR: begin
        awvalid = 1'b1;
        if (awready) begin
          beat_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        wvalid = 1'b1;
        wlast  = (beat_q == BEAT_W'(BEATS - 1));
        if (wready) begin
          if (wlast) begin
            beat_d  = '0;
            state_d = S_RESP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_RESP: begin
        bready = 1'b1;
        // The entry leaves the FIFO only once memory has acknowledged it, error or not.
        if (bvalid) begin
          vc_pop  = 1'b1;
          bus_err = (bresp != 2'b00);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign awaddr     = {label_q, {LINE_BYTE_OFFSET{1'b0}}};
  assign awlen      = 8'(BEATS - 1);
  assign wdata      = data_q[int'(beat_q) * BUS_WIDTH +: BUS_WIDTH];
  assign wstrb      = {(BUS_WIDTH / 8){1'b1}};
  assign lock_hit   = (state_q != S_IDLE) && (label_q == query_label);
  assign flush_done = flush_req && vc_empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_victim_wb_ctrl.sv
// Directed bench for victim_wb_ctrl: a small victim-FIFO model feeds lines while
// the bus side is driven step by step with known ready/response patterns.
module tb_victim_wb_ctrl;
  import victim_wb_pkg::*;

  localparam int LINE_WIDTH  = 256;
  localparam int BUS_WIDTH   = 32;
  localparam int LABEL_WIDTH = 27;
  localparam int RW          = LABEL_WIDTH + LINE_WIDTH;

  typedef enum int {P_IDLE, P_ADDR, P_DATA, P_RESP} phase_e;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [RW-1:0]          vc_rline = '0;
  logic                   vc_empty = 1'b1;
  logic                   vc_pop;
  logic [LABEL_WIDTH-1:0] query_label;
  logic                   lock_hit;
  logic                   flush_req;
  logic                   flush_done;
  logic [31:0]            awaddr;
  logic [7:0]             awlen;
  logic                   awvalid, awready;
  logic [31:0]            wdata;
  logic [3:0]             wstrb;
  logic                   wlast, wvalid, wready;
  logic                   bvalid, bready;
  logic [1:0]             bresp;
  logic                   bus_err;

  int checks    = 0;
  int failures  = 0;
  int pop_count = 0;

  logic [RW-1:0] fifo [$];
  logic [RW-1:0] push_lines [8];
  int            push_n = 0;

  victim_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .vc_rline(vc_rline), .vc_empty(vc_empty), .vc_pop(vc_pop),
    .query_label(query_label), .lock_hit(lock_hit),
    .flush_req(flush_req), .flush_done(flush_done),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Victim FIFO model: pops on vc_pop, empty/head update on the following edge.
  always @(posedge clk) begin
    if (vc_pop) pop_count <= pop_count + 1;
    if (rst) begin
      fifo.delete();
    end else begin
      if (vc_pop && fifo.size() != 0) void'(fifo.pop_front());
      for (int i = 0; i < push_n; i++) fifo.push_back(push_lines[i]);
    end
    vc_empty <= (fifo.size() == 0);
    vc_rline <= (fifo.size() == 0) ? '0 : fifo[0];
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int n);
    push_n = n;
    tick();
    push_n = 0;
  endtask

  // Drives one burst from its IDLE cycle to the pop edge, checking every cycle.
  task automatic drain(input logic [LABEL_WIDTH-1:0] label, input logic [LINE_WIDTH-1:0] data,
                       input int aw_stall, input bit w_toggle, input int b_delay,
                       input logic [1:0] resp, output int pop_cyc,
                       output logic [31:0] first_word, output logic [31:0] last_word,
                       output logic [31:0] seen_addr);
    phase_e ph   = P_IDLE;
    int     cnt  = 0;
    int     beat = 0;
    bit     done = 1'b0;
    pop_cyc    = -1;
    first_word = '0;
    last_word  = '0;
    seen_addr  = '0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      awready     = (ph == P_ADDR) && (cnt >= aw_stall);
      wready      = (ph == P_DATA) && (!w_toggle || (cnt % 2 == 0));
      bvalid      = (ph == P_RESP) && (cnt >= b_delay);
      bresp       = bvalid ? resp : 2'b00;
      query_label = (cnt % 2 == 1) ? label + 27'd1 : label;
      #1;
      check("awvalid", awvalid, ph == P_ADDR);
      check("wvalid", wvalid, ph == P_DATA);
      check("bready", bready, ph == P_RESP);
      check("lock_hit", lock_hit, (ph != P_IDLE) && (cnt % 2 == 0));
      check("vc_pop", vc_pop, (ph == P_RESP) && bvalid);
      check("bus_err", bus_err, (ph == P_RESP) && bvalid && (resp != 2'b00));
      check("flush_done_busy", flush_done, 1'b0);
      if (ph == P_ADDR) begin
        check("awaddr", awaddr, {label, 5'b0});
        check("awlen", awlen, 8'd7);
        if (awready) seen_addr = awaddr;
      end
      if (ph == P_DATA) begin
        check("wdata", wdata, data[beat*BUS_WIDTH +: BUS_WIDTH]);
        check("wlast", wlast, beat == 7);
        check("wstrb", wstrb, 4'hf);
        if (wready && beat == 0) first_word = wdata;
        if (wready && beat == 7) last_word  = wdata;
      end
      case (ph)
        P_IDLE: begin ph = P_ADDR; cnt = 0; end
        P_ADDR: if (awready) begin ph = P_DATA; cnt = 0; end else cnt++;
        P_DATA: begin
          if (wready) beat++;
          if (wready && beat == 8) begin ph = P_RESP; cnt = 0; end else cnt++;
        end
        P_RESP: if (bvalid) begin done = 1'b1; pop_cyc = cyc; end else cnt++;
        default: ph = P_IDLE;
      endcase
      tick();
    end
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    check("burst_done", done, 1'b1);
    check("beats", beat, 8);
  endtask

  logic [LINE_WIDTH-1:0] d1, d2, dl;
  int                    pc;
  logic [31:0]           fw, lw, sa;

  initial begin
    rst = 1'b1; flush_req = 1'b0; query_label = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    for (int i = 0; i < 32; i++) d1[i*8 +: 8] = 8'(i + 1);
    d2 = ~d1;

    // Reset state
    repeat (3) tick();
    #1;
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_wlast", wlast, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_vc_pop", vc_pop, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_lock_hit", lock_hit, 1'b0);
    check("rst_flush_done_noreq", flush_done, 1'b0);
    flush_req = 1'b1;
    #1;
    check("rst_flush_done_req", flush_done, 1'b1);
    flush_req = 1'b0;
    rst = 1'b0;
    tick();

    // Single line, all-ready bus
    push_lines[0] = {27'h0000123, d1};
    push(1);
    drain(27'h0000123, d1, 0, 1'b0, 0, 2'b00, pc, fw, lw, sa);
    check("t1_pop_cycle", pc + 1, 11);
    check("t1_awaddr", sa, 32'h0000_2460);
    check("t1_word0", fw, 32'h0403_0201);
    check("t1_word7", lw, 32'h201f_1e1d);
    check("t1_pops", pop_count, 1);

    // Backpressure: awready stalled 3, wready toggling, bvalid delayed 5
    push_lines[0] = {27'h0004567, d2};
    push(1);
    drain(27'h0004567, d2, 3, 1'b1, 5, 2'b00, pc, fw, lw, sa);
    check("t2_pop_cycle", pc, 25);
    check("t2_pops", pop_count, 2);

    // Full FIFO with flush requested
    flush_req = 1'b1;
    #1;
    check("t3_flush_done_before", flush_done, 1'b1);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) dl[k*32 +: 32] = 32'h5A00_0000 | 32'(i << 8) | 32'(k);
      push_lines[i] = {27'(27'h200 + i), dl};
    end
    push(8);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) dl[k*32 +: 32] = 32'h5A00_0000 | 32'(i << 8) | 32'(k);
      drain(27'(27'h200 + i), dl, 0, 1'b0, 0, 2'b00, pc, fw, lw, sa);
      check("t3_pop_cycle", pc, 10);
      check("t3_word7", lw, 32'h5A00_0007 | 32'(i << 8));
    end
    #1;
    check("t3_flush_done_after", flush_done, 1'b1);
    check("t3_pops", pop_count, 10);
    flush_req = 1'b0;

    // Error response, then a normal line
    push_lines[0] = {27'h00003A0, d1};
    push_lines[1] = {27'h00003A1, d2};
    push(2);
    drain(27'h00003A0, d1, 0, 1'b0, 0, 2'b10, pc, fw, lw, sa);
    check("t5_err_pops", pop_count, 11);
    drain(27'h00003A1, d2, 0, 1'b0, 0, 2'b00, pc, fw, lw, sa);
    check("t5_next_pop_cycle", pc, 10);
    check("t5_pops", pop_count, 12);

    // Reset asserted on beat 4
    push_lines[0] = {27'h0000ABC, d1};
    push(1);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; query_label = 27'h0000ABC;
    repeat (6) tick();
    #1;
    check("t6_wvalid_b4", wvalid, 1'b1);
    check("t6_wdata_b4", wdata, 32'h1413_1211);
    check("t6_lock_b4", lock_hit, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_pop_in_rst", vc_pop, 1'b0);
    tick();
    #1;
    check("t6_awvalid", awvalid, 1'b0);
    check("t6_wvalid", wvalid, 1'b0);
    check("t6_wlast", wlast, 1'b0);
    check("t6_bready", bready, 1'b0);
    check("t6_vc_pop", vc_pop, 1'b0);
    check("t6_bus_err", bus_err, 1'b0);
    check("t6_lock_hit", lock_hit, 1'b0);
    check("t6_awaddr", awaddr, 32'h0);
    check("t6_wdata", wdata, 32'h0);
    check("t6_pops", pop_count, 12);
    rst = 1'b0; awready = 1'b0; wready = 1'b0; flush_req = 1'b1;
    tick();
    #1;
    check("t6_idle_awvalid", awvalid, 1'b0);
    check("t6_flush_done", flush_done, 1'b1);
    check("t6_pops_final", pop_count, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
